// File: rtl/contador16_sched.sv
// Round-robin scheduler sharing one contador16 as a one-shot down-timer between two requesters.
// Every output is registered; the counter is loaded (MODO=11) and then counted down (MODO=01) until RCO.
module contador16_sched #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] LOAD0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] LOAD1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             BUSY,
    output logic             OWNER,
    output logic             ENB,
    output logic [1:0]       MODO,
    output logic [WIDTH-1:0] entrada,
    input  logic             RCO,
    input  logic [WIDTH-1:0] salida
);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_load  = 2'd1,
        st_count = 2'd2,
        st_done  = 2'd3
    } state_t;

    localparam logic [1:0] modo_up   = 2'b00;
    localparam logic [1:0] modo_down = 2'b01;
    localparam logic [1:0] modo_load = 2'b11;

    state_t           state_reg, state_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic             enb_reg, enb_next;
    logic [1:0]       modo_reg, modo_next;
    logic [WIDTH-1:0] entrada_reg, entrada_next;
    logic             win;

    logic [1:0]       req;
    logic [WIDTH-1:0] load [2];

    // The count value is observed by other blocks; this scheduler only watches RCO.
    logic             salida_unused;
    assign salida_unused = ^salida;

    assign req     = {REQ1, REQ0};
    assign load[0] = LOAD0;
    assign load[1] = LOAD1;

    always_comb begin
        state_next   = state_reg;
        gnt_next     = '0;
        done_next    = '0;
        busy_next    = 1'b1;
        owner_next   = owner_reg;
        last_next    = last_reg;
        enb_next     = 1'b0;
        modo_next    = modo_up;
        entrada_next = entrada_reg;
        win          = 1'b0;
        case (state_reg)
            st_idle: begin
                busy_next = 1'b0;
                if (req != 2'b00) begin
                    // On a tie the requester that did not win last time goes first.
                    win           = (req == 2'b11) ? ~last_reg : req[1];
                    gnt_next[win] = 1'b1;
                    owner_next    = win;
                    last_next     = win;
                    entrada_next  = load[win];
                    busy_next     = 1'b1;
                    if (load[win] != '0) begin
                        state_next = st_load;
                        enb_next   = 1'b1;
                        modo_next  = modo_load;
                    end else begin
                        state_next     = st_done;
                        done_next[win] = 1'b1;
                    end
                end
            end
            st_load: begin
                state_next = st_count;
                enb_next   = 1'b1;
                modo_next  = modo_down;
            end
            st_count: begin
                if (RCO) begin
                    state_next           = st_done;
                    done_next[owner_reg] = 1'b1;
                end else begin
                    enb_next  = 1'b1;
                    modo_next = modo_down;
                end
            end
            st_done: begin
                state_next = st_idle;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = st_idle;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_reg   <= st_idle;
            gnt_reg     <= '0;
            done_reg    <= '0;
            busy_reg    <= 1'b0;
            owner_reg   <= 1'b0;
            last_reg    <= 1'b1;
            enb_reg     <= 1'b0;
            modo_reg    <= modo_up;
            entrada_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            enb_reg     <= enb_next;
            modo_reg    <= modo_next;
            entrada_reg <= entrada_next;
        end
    end

    assign GNT0    = gnt_reg[0];
    assign GNT1    = gnt_reg[1];
    assign DONE0   = done_reg[0];
    assign DONE1   = done_reg[1];
    assign BUSY    = busy_reg;
    assign OWNER   = owner_reg;
    assign ENB     = enb_reg;
    assign MODO    = modo_reg;
    assign entrada = entrada_reg;

endmodule

// File: doc/contador16_sched.md
Name: contador16_sched

Overview:
- Two-requester scheduler that shares one contador16 instance as a one-shot down-timer.
- Arbitrates round-robin between requesters and latches the winner's 16-bit count.
- Programs the counter by loading (MODO=11), then counting down (MODO=01) until the counter raises RCO, then reports completion to the owner.
- Sits between the requesting blocks and contador16; it owns that counter's CLK-domain control inputs (ENB, MODO, entrada).

Parameters:
WIDTH, 16, counter/load value width (matches contador16)

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_L  input  1  synchronous reset, active-low
REQ0  input  1  requester 0 wants the timer (level)
LOAD0  input  WIDTH  requester 0 count value, sampled at grant
REQ1  input  1  requester 1 wants the timer (level)
LOAD1  input  WIDTH  requester 1 count value, sampled at grant
GNT0  output  1  one-cycle pulse: requester 0 accepted
GNT1  output  1  one-cycle pulse: requester 1 accepted
DONE0  output  1  one-cycle pulse: requester 0 timer expired
DONE1  output  1  one-cycle pulse: requester 1 timer expired
BUSY  output  1  high whenever state is not IDLE
OWNER  output  1  index of the current/last granted requester
ENB  output  1  to contador16 ENB
MODO  output  2  to contador16 MODO (00 up, 01 down, 10 down-by-3, 11 load)
entrada  output  WIDTH  to contador16 entrada
RCO  input  1  from contador16, terminal-count flag
salida  input  WIDTH  from contador16 count value, monitor only; the scheduler does not use it for control

Behaviour:
- All outputs are registered.
- Reset (RESET_L=0 at a rising edge): state IDLE; GNT*/DONE*=0; BUSY=0; OWNER=0; ENB=0; MODO=00; entrada=0; round-robin pointer set so requester 0 wins the first tie. Reset mid-operation aborts the job; no DONE is issued.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - ENB=0, MODO=00. REQx is sampled only here.
  - Single request: that requester wins.
  - Both requests: the requester that was not granted last wins.
- Grant at edge t (REQ seen in IDLE):
  - From t+1: GNTx=1 for exactly one cycle, OWNER=x, entrada=LOADx (held until the next grant), BUSY=1.
  - If LOADx != 0: state LOAD, ENB=1, MODO=11 for exactly one cycle.
  - If LOADx == 0: state DONE directly; the counter is not touched (ENB stays 0); GNTx and DONEx assert in the same cycle.
- LOAD → COUNT unconditionally. RCO is ignored while in LOAD.
- COUNT:
  - ENB=1, MODO=01.
  - Stays in COUNT while RCO=0.
  - When RCO=1 is sampled, the next cycle is DONE.
- DONE:
  - ENB=0, MODO=00, DONE[OWNER]=1 for one cycle, BUSY=1.
  - Next cycle returns to IDLE and BUSY=0.
- Minimum gap between jobs: one IDLE cycle. A held REQ re-arbitrates in that cycle.
- Changing REQx or LOADx after grant has no effect on the running job.
- DONE0/DONE1 and GNT0/GNT1 are never high simultaneously.

Test Plan:
- Reset: RESET_L=0 for 2 cycles, with REQ0=1 during reset → all outputs 0, no GNT while reset is asserted; first GNT0 appears the cycle after RESET_L rises plus one.
- Single job: REQ0=1, LOAD0=16'd5 → GNT0 pulse; one cycle of MODO=11, entrada=5; then MODO=01 until RCO; DONE0 pulses one cycle after RCO=1; BUSY falls the following cycle.
- Contention: REQ0=REQ1=1 held, LOAD0=3, LOAD1=4 → grants alternate GNT0, GNT1, GNT0… with a DONE between each, never two consecutive grants to the same requester.
- Zero load: REQ1=1, LOAD1=0 → GNT1 and DONE1 high in the same cycle; ENB stays 0 throughout; BUSY high for exactly 1 cycle.
- Reset mid-COUNT: RESET_L=0 while in COUNT with LOAD0=16'hFFFF → ENB=0, MODO=00 and BUSY=0 next edge; no DONE0 ever issued for that job.
- Late change: grant REQ1 with LOAD1=10, then change LOAD1 to 2 and drop REQ1 during COUNT → entrada stays 10; DONE1 still pulses on RCO.
